// File: rtl/decode_basic.sv
// decode_basic: one-entry RV32I decode stage with JAL redirect and execute squash forwarding
module decode_basic #(
  parameter int p_addr_bits = 32,
  parameter int p_inst_bits = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   f_val,
  output logic                   f_rdy,
  input  logic [p_inst_bits-1:0] f_inst,
  input  logic [p_addr_bits-1:0] f_pc,
  output logic                   f_squash,
  output logic [p_addr_bits-1:0] f_branch_target,
  output logic                   x_val,
  input  logic                   x_rdy,
  output logic [p_addr_bits-1:0] x_pc,
  output logic [3:0]             x_op,
  output logic [2:0]             x_funct3,
  output logic                   x_funct7b5,
  output logic [4:0]             x_rd,
  output logic [4:0]             x_rs1,
  output logic [4:0]             x_rs2,
  output logic                   x_wen,
  output logic [31:0]            x_imm,
  input  logic                   x_squash,
  input  logic [p_addr_bits-1:0] x_branch_target
);
  localparam logic [3:0] OP_ILLEGAL = 4'd0, OP_LUI = 4'd1, OP_AUIPC = 4'd2, OP_JAL = 4'd3,
                         OP_JALR = 4'd4, OP_BRANCH = 4'd5, OP_LOAD = 4'd6, OP_STORE = 4'd7,
                         OP_OPIMM = 4'd8, OP_OP = 4'd9;
  logic                   valid_q, valid_d;
  logic [p_inst_bits-1:0] inst_q, inst_d;
  logic [p_addr_bits-1:0] pc_q, pc_d;
  logic                   f_xfer, x_xfer;
  logic [31:0]            i;
  logic [31:0]            imm_i, imm_s, imm_b, imm_u, imm_j;
  assign i = inst_q[31:0];
  assign imm_i = {{20{i[31]}}, i[31:20]};
  assign imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
  assign imm_b = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  assign imm_u = {i[31:12], 12'b0};
  assign imm_j = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  always_comb begin
    case (i[6:0])
      7'b0110111: x_op = OP_LUI;
      7'b0010111: x_op = OP_AUIPC;
      7'b1101111: x_op = OP_JAL;
      7'b1100111: x_op = OP_JALR;
      7'b1100011: x_op = OP_BRANCH;
      7'b0000011: x_op = OP_LOAD;
      7'b0100011: x_op = OP_STORE;
      7'b0010011: x_op = OP_OPIMM;
      7'b0110011: x_op = OP_OP;
      default:    x_op = OP_ILLEGAL;
    endcase
  end
  always_comb begin
    x_imm = (x_op == OP_OPIMM || x_op == OP_LOAD || x_op == OP_JALR) ? imm_i :
            (x_op == OP_STORE)                    ? imm_s :
            (x_op == OP_BRANCH)                   ? imm_b :
            (x_op == OP_LUI || x_op == OP_AUIPC)  ? imm_u :
            (x_op == OP_JAL)                      ? imm_j : 32'd0;
    x_wen = (x_op != OP_ILLEGAL && x_op != OP_BRANCH && x_op != OP_STORE) && (x_rd != 5'd0);
  end
  assign x_funct3   = i[14:12];
  assign x_funct7b5 = i[30];
  assign x_rd       = i[11:7];
  assign x_rs1      = i[19:15];
  assign x_rs2      = i[24:20];
  assign x_pc       = pc_q;
  assign x_val      = valid_q && !x_squash;
  assign f_rdy      = !valid_q || x_rdy;
  assign f_xfer     = f_val && f_rdy;
  assign x_xfer     = x_val && x_rdy;
  assign f_squash   = x_squash || (x_xfer && x_op == OP_JAL);
  assign f_branch_target = x_squash ? x_branch_target : pc_q + p_addr_bits'($signed(x_imm));
  always_comb begin
    valid_d = (f_xfer && !f_squash) ? 1'b1 : (x_xfer || x_squash) ? 1'b0 : valid_q;
    inst_d  = (f_xfer && !f_squash) ? f_inst : inst_q;
    pc_d    = (f_xfer && !f_squash) ? f_pc : pc_q;
  end
  always_ff @(posedge clk) begin
    valid_q <= rst ? 1'b0 : valid_d;
    inst_q  <= inst_d;
    pc_q    <= pc_d;
  end
endmodule

// File: tb/tb_decode_basic.sv
// tb_decode_basic: randomized and directed checks of decode_basic against a spec-level model
module tb_decode_basic;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_val = 1'b0;
  logic        f_rdy;
  logic [31:0] f_inst = '0;
  logic [31:0] f_pc = '0;
  logic        f_squash;
  logic [31:0] f_branch_target;
  logic        x_val;
  logic        x_rdy = 1'b0;
  logic [31:0] x_pc;
  logic [3:0]  x_op;
  logic [2:0]  x_funct3;
  logic        x_funct7b5;
  logic [4:0]  x_rd, x_rs1, x_rs2;
  logic        x_wen;
  logic [31:0] x_imm;
  logic        x_squash = 1'b0;
  logic [31:0] x_branch_target = '0;
  int errors = 0;
  int checks = 0;
  decode_basic dut (
    .clk(clk), .rst(rst), .f_val(f_val), .f_rdy(f_rdy), .f_inst(f_inst), .f_pc(f_pc),
    .f_squash(f_squash), .f_branch_target(f_branch_target), .x_val(x_val), .x_rdy(x_rdy),
    .x_pc(x_pc), .x_op(x_op), .x_funct3(x_funct3), .x_funct7b5(x_funct7b5), .x_rd(x_rd),
    .x_rs1(x_rs1), .x_rs2(x_rs2), .x_wen(x_wen), .x_imm(x_imm), .x_squash(x_squash),
    .x_branch_target(x_branch_target)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [3:0] ref_op(input logic [31:0] inst);
    case (inst[6:0])
      7'h37: return 4'd1;
      7'h17: return 4'd2;
      7'h6F: return 4'd3;
      7'h67: return 4'd4;
      7'h63: return 4'd5;
      7'h03: return 4'd6;
      7'h23: return 4'd7;
      7'h13: return 4'd8;
      7'h33: return 4'd9;
      default: return 4'd0;
    endcase
  endfunction
  function automatic logic [31:0] ref_imm(input logic [31:0] inst);
    logic signed [11:0] ii;
    logic signed [11:0] ss;
    logic signed [12:0] bb;
    logic signed [20:0] jj;
    int v;
    ii = inst[31:20];
    ss = {inst[31:25], inst[11:7]};
    bb = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    jj = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    case (ref_op(inst))
      4'd4, 4'd6, 4'd8: v = ii;
      4'd7: v = ss;
      4'd5: v = bb;
      4'd1, 4'd2: v = int'(inst & 32'hFFFFF000);
      4'd3: v = jj;
      default: v = 0;
    endcase
    return 32'(v);
  endfunction
  function automatic logic ref_wen(input logic [31:0] inst);
    logic [3:0] op;
    op = ref_op(inst);
    return (op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd8, 4'd9}) && (inst[11:7] != 5'd0);
  endfunction
  task automatic test_reset();
    rst = 1'b1; f_val = 1'b0; x_rdy = 1'b0; x_squash = 1'b0;
    tick(); tick();
    checks += 3;
    if (x_val !== 1'b0) begin errors++; $display("FAIL reset_x_val got=%b exp=0", x_val); end
    if (f_squash !== 1'b0) begin errors++; $display("FAIL reset_f_squash got=%b exp=0", f_squash); end
    if (f_rdy !== 1'b1) begin errors++; $display("FAIL reset_f_rdy got=%b exp=1", f_rdy); end
    rst = 1'b0;
  endtask
  task automatic test_addi();
    f_val = 1'b1; f_inst = 32'h00500093; f_pc = 32'h200; x_rdy = 1'b1;
    tick();
    f_val = 1'b0;
    #1;
    checks += 7;
    if (x_val !== 1'b1) begin errors++; $display("FAIL addi_val got=%b exp=1", x_val); end
    if (x_op !== 4'd8) begin errors++; $display("FAIL addi_op got=%0d exp=8", x_op); end
    if (x_rd !== 5'd1) begin errors++; $display("FAIL addi_rd got=%0d exp=1", x_rd); end
    if (x_rs1 !== 5'd0) begin errors++; $display("FAIL addi_rs1 got=%0d exp=0", x_rs1); end
    if (x_imm !== 32'd5) begin errors++; $display("FAIL addi_imm got=%h exp=5", x_imm); end
    if (x_wen !== 1'b1) begin errors++; $display("FAIL addi_wen got=%b exp=1", x_wen); end
    if (x_pc !== 32'h200) begin errors++; $display("FAIL addi_pc got=%h exp=200", x_pc); end
    tick();
  endtask
  task automatic test_back_to_back();
    x_rdy = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      f_val = (k < 4);
      f_inst = {7'b0100000, 5'd3, 5'd2, 3'b000, 5'(k + 10), 7'b0110011};
      f_pc = 32'h300 + 32'(4 * k);
      #1;
      checks++;
      if (f_rdy !== 1'b1) begin errors++; $display("FAIL b2b_f_rdy cycle=%0d got=%b exp=1", k, f_rdy); end
      if (k > 0) begin
        checks += 4;
        if (x_val !== 1'b1) begin errors++; $display("FAIL b2b_val cycle=%0d got=%b exp=1", k, x_val); end
        if (x_rd !== 5'(k + 9)) begin errors++; $display("FAIL b2b_rd cycle=%0d got=%0d exp=%0d", k, x_rd, k + 9); end
        if (x_pc !== 32'h300 + 32'(4 * (k - 1))) begin errors++; $display("FAIL b2b_pc cycle=%0d got=%h", k, x_pc); end
        if (x_op !== 4'd9 || x_funct7b5 !== 1'b1) begin errors++; $display("FAIL b2b_op cycle=%0d got=%0d/%b exp=9/1", k, x_op, x_funct7b5); end
      end
      tick();
    end
    f_val = 1'b0;
  endtask
  task automatic test_stall();
    f_val = 1'b1; f_inst = 32'hFFC10193; f_pc = 32'h400; x_rdy = 1'b0;
    tick();
    f_inst = 32'h00A00213; f_pc = 32'h404;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks += 4;
      if (f_rdy !== 1'b0) begin errors++; $display("FAIL stall_f_rdy cycle=%0d got=%b exp=0", k, f_rdy); end
      if (x_val !== 1'b1) begin errors++; $display("FAIL stall_val cycle=%0d got=%b exp=1", k, x_val); end
      if (x_rd !== 5'd3 || x_pc !== 32'h400) begin errors++; $display("FAIL stall_hold cycle=%0d rd=%0d pc=%h exp=3/400", k, x_rd, x_pc); end
      if (x_imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL stall_imm cycle=%0d got=%h exp=fffffffc", k, x_imm); end
      tick();
    end
    x_rdy = 1'b1;
    #1;
    checks++;
    if (f_rdy !== 1'b1 || x_val !== 1'b1) begin errors++; $display("FAIL release_both got=%b/%b exp=1/1", f_rdy, x_val); end
    tick();
    f_val = 1'b0;
    #1;
    checks++;
    if (x_val !== 1'b1 || x_rd !== 5'd4 || x_pc !== 32'h404) begin errors++; $display("FAIL release_next val=%b rd=%0d pc=%h exp=1/4/404", x_val, x_rd, x_pc); end
    tick();
  endtask
  task automatic test_jal();
    f_val = 1'b1; f_inst = 32'h0100006F; f_pc = 32'h1000; x_rdy = 1'b1;
    tick();
    f_inst = 32'h00500093; f_pc = 32'h1004;
    #1;
    checks += 5;
    if (x_op !== 4'd3) begin errors++; $display("FAIL jal_op got=%0d exp=3", x_op); end
    if (f_squash !== 1'b1) begin errors++; $display("FAIL jal_squash got=%b exp=1", f_squash); end
    if (f_branch_target !== 32'h1010) begin errors++; $display("FAIL jal_target got=%h exp=1010", f_branch_target); end
    if (x_wen !== 1'b0) begin errors++; $display("FAIL jal_wen got=%b exp=0", x_wen); end
    if (x_val !== 1'b1) begin errors++; $display("FAIL jal_val got=%b exp=1", x_val); end
    tick();
    f_val = 1'b0;
    #1;
    checks += 2;
    if (x_val !== 1'b0) begin errors++; $display("FAIL jal_drop got=%b exp=0", x_val); end
    if (f_squash !== 1'b0) begin errors++; $display("FAIL jal_one_cycle got=%b exp=0", f_squash); end
    tick();
  endtask
  task automatic test_squash_jal();
    f_val = 1'b1; f_inst = 32'h0100006F; f_pc = 32'h2000; x_rdy = 1'b1;
    tick();
    f_val = 1'b0; x_squash = 1'b1; x_branch_target = 32'h40;
    #1;
    checks += 3;
    if (x_val !== 1'b0) begin errors++; $display("FAIL xsq_val got=%b exp=0", x_val); end
    if (f_squash !== 1'b1) begin errors++; $display("FAIL xsq_squash got=%b exp=1", f_squash); end
    if (f_branch_target !== 32'h40) begin errors++; $display("FAIL xsq_target got=%h exp=40", f_branch_target); end
    tick();
    x_squash = 1'b0;
    #1;
    checks += 2;
    if (x_val !== 1'b0) begin errors++; $display("FAIL xsq_cleared got=%b exp=0", x_val); end
    if (f_squash !== 1'b0) begin errors++; $display("FAIL xsq_after got=%b exp=0", f_squash); end
  endtask
  task automatic test_imm_edges();
    x_rdy = 1'b1;
    f_val = 1'b1; f_inst = 32'hFE000EE3; f_pc = 32'h8;
    tick();
    f_inst = 32'hFFFFFFFF; f_pc = 32'hC;
    #1;
    checks += 3;
    if (x_op !== 4'd5) begin errors++; $display("FAIL beq_op got=%0d exp=5", x_op); end
    if (x_imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL beq_imm got=%h exp=fffffffc", x_imm); end
    if (x_wen !== 1'b0) begin errors++; $display("FAIL beq_wen got=%b exp=0", x_wen); end
    tick();
    f_val = 1'b0;
    #1;
    checks += 3;
    if (x_op !== 4'd0) begin errors++; $display("FAIL illegal_op got=%0d exp=0", x_op); end
    if (x_wen !== 1'b0) begin errors++; $display("FAIL illegal_wen got=%b exp=0", x_wen); end
    if (x_imm !== 32'd0) begin errors++; $display("FAIL illegal_imm got=%h exp=0", x_imm); end
    tick();
  endtask
  task automatic test_random();
    logic [6:0]  opcs [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    logic        m_valid;
    logic [31:0] m_inst, m_pc, r;
    logic        e_rdy, e_val, e_xfer, e_sq;
    m_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      f_val = ($urandom_range(0, 9) < 7);
      f_inst = ($urandom_range(0, 9) == 0) ? $urandom() : {r[31:7], opcs[$urandom_range(0, 8)]};
      f_pc = $urandom();
      x_rdy = ($urandom_range(0, 9) < 7);
      x_squash = ($urandom_range(0, 9) == 0);
      x_branch_target = $urandom();
      rst = ($urandom_range(0, 49) == 0);
      #1;
      e_rdy = !m_valid || x_rdy;
      e_val = m_valid && !x_squash;
      e_xfer = e_val && x_rdy;
      e_sq = x_squash || (e_xfer && ref_op(m_inst) == 4'd3);
      checks += 3;
      if (f_rdy !== e_rdy) begin errors++; $display("FAIL rnd_f_rdy n=%0d got=%b exp=%b", n, f_rdy, e_rdy); end
      if (x_val !== e_val) begin errors++; $display("FAIL rnd_x_val n=%0d got=%b exp=%b", n, x_val, e_val); end
      if (f_squash !== e_sq) begin errors++; $display("FAIL rnd_f_squash n=%0d got=%b exp=%b", n, f_squash, e_sq); end
      if (e_sq) begin
        checks++;
        if (f_branch_target !== (x_squash ? x_branch_target : m_pc + ref_imm(m_inst))) begin
          errors++; $display("FAIL rnd_target n=%0d got=%h inst=%h pc=%h", n, f_branch_target, m_inst, m_pc);
        end
      end
      if (e_val) begin
        checks += 4;
        if (x_op !== ref_op(m_inst)) begin errors++; $display("FAIL rnd_op n=%0d got=%0d exp=%0d inst=%h", n, x_op, ref_op(m_inst), m_inst); end
        if (x_imm !== ref_imm(m_inst)) begin errors++; $display("FAIL rnd_imm n=%0d got=%h exp=%h inst=%h", n, x_imm, ref_imm(m_inst), m_inst); end
        if (x_wen !== ref_wen(m_inst)) begin errors++; $display("FAIL rnd_wen n=%0d got=%b exp=%b inst=%h", n, x_wen, ref_wen(m_inst), m_inst); end
        if ({x_pc, x_rd, x_rs1, x_rs2, x_funct3, x_funct7b5} !==
            {m_pc, m_inst[11:7], m_inst[19:15], m_inst[24:20], m_inst[14:12], m_inst[30]}) begin
          errors++; $display("FAIL rnd_fields n=%0d pc=%h rd=%0d rs1=%0d rs2=%0d exp_pc=%h inst=%h", n, x_pc, x_rd, x_rs1, x_rs2, m_pc, m_inst);
        end
      end
      if (rst) m_valid = 1'b0;
      else if (f_val && e_rdy && !e_sq) begin m_valid = 1'b1; m_inst = f_inst; m_pc = f_pc; end
      else if (e_xfer || x_squash) m_valid = 1'b0;
      tick();
    end
    rst = 1'b0; f_val = 1'b0; x_squash = 1'b0;
  endtask
  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_stall();
    test_jal();
    test_squash_jal();
    test_imm_edges();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
